// File: rtl/display_page_scheduler.sv
// display_page_scheduler
//   Drives the 4-digit seven-segment scan and decides which page the
//   segment decoder shows. A prescaler splits each digit slot into a
//   blanking interval (all anodes off, against ghosting) and a lit
//   interval. A small FSM shares the display between the status page and
//   three event pages. It changes pages only on frame boundaries and keeps
//   each granted event page up for HOLD_FRAMES full frames.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       1 = scan runs, 0 = scan frozen and display blanked
//   ev_req[2:0]  one-cycle event pulses: [0] colour, [1] IR, [2] fault
//   ev_ack[2:0]  one-hot one-cycle pulse when an event page is granted
//   page[1:0]    0 status, 1 colour, 2 IR, 3 fault
//   an[3:0]      active-low anode enables, digit0 (leftmost) = 4'b0111
//   digit[1:0]   index of the slot currently on the anodes
//   digit_valid  1 while an anode is driven
//   frame_tick   one-cycle pulse in the cycle digit wraps 3 -> 0
module display_page_scheduler #(
  parameter int REFRESH_DIV = 131072,
  parameter int BLANK_CYC   = 64,
  parameter int HOLD_FRAMES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] ev_req,
  output logic [2:0] ev_ack,
  output logic [1:0] page,
  output logic [3:0] an,
  output logic [1:0] digit,
  output logic       digit_valid,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_FRAMES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Scan counters
  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit_cnt;
  // Registered display outputs
  logic [1:0]    r_digit;
  logic [3:0]    r_an;
  logic          r_digit_valid;
  logic          r_frame_tick;
  // Scheduler
  state_t        r_state, w_state_next;
  logic [1:0]    r_page, w_page_next;
  logic [2:0]    r_ev_ack, w_ev_ack_next;
  logic [2:0]    r_pending, w_clear;
  logic [HW-1:0] r_hold, w_hold_next;
  logic          w_grant;

  logic          w_wrap;
  logic          w_lit;
  logic [3:0]    w_an_sel;
  logic [1:0]    w_hi_idx;
  logic [2:0]    w_hi_onehot;

  assign w_wrap   = enable && (r_presc == PRESC_LAST);
  assign w_lit    = enable && (r_presc >= BLANK_END);
  assign w_an_sel = ~(4'b1000 >> r_digit_cnt);

  // Scan counters freeze while enable is low so the slot resumes where it
  // stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_digit_cnt <= 2'd0;
    end else if (enable) begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) begin
        r_digit_cnt <= r_digit_cnt + 2'd1;
      end
    end
  end

  // The output stage trails the counters by one cycle. A page change one
  // cycle after frame_tick therefore still lands inside blanking, given
  // BLANK_CYC >= 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an          <= 4'b1111;
      r_digit_valid <= 1'b0;
      r_digit       <= 2'd0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_an          <= w_lit ? w_an_sel : 4'b1111;
      r_digit_valid <= w_lit;
      r_digit       <= r_digit_cnt;
      r_frame_tick  <= (r_digit == 2'd3) && (r_digit_cnt == 2'd0);
    end
  end

  // Highest-priority pending event (fault > IR > colour)
  always_comb begin
    w_hi_idx = 2'd0;
    if (r_pending[2]) begin
      w_hi_idx = 2'd2;
    end else if (r_pending[1]) begin
      w_hi_idx = 2'd1;
    end
  end
  assign w_hi_onehot = 3'b001 << w_hi_idx;

  always_comb begin
    w_state_next  = r_state;
    w_page_next   = r_page;
    w_ev_ack_next = 3'b000;
    w_hold_next   = r_hold;
    w_clear       = 3'b000;
    w_grant       = 1'b0;
    if (r_frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            w_grant = 1'b1;
          end
        end
        ST_SHOW: begin
          // A fault preempts a lower page. On expiry, the next pending page
          // goes straight up with no status frame in between.
          if ((r_pending[2] && (r_page != 2'd3)) || ((r_hold == '0) && (|r_pending))) begin
            w_grant = 1'b1;
          end else if (r_hold != '0) begin
            w_hold_next = r_hold - HW'(1);
          end else begin
            w_state_next = ST_IDLE;
            w_page_next  = 2'd0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_page_next  = 2'd0;
        end
      endcase
    end
    if (w_grant) begin
      w_state_next  = ST_SHOW;
      w_page_next   = w_hi_idx + 2'd1;
      w_ev_ack_next = w_hi_onehot;
      w_clear       = w_hi_onehot;
      w_hold_next   = HOLD_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_page    <= 2'd0;
      r_ev_ack  <= 3'b000;
      r_hold    <= '0;
      r_pending <= 3'b000;
    end else begin
      r_state   <= w_state_next;
      r_page    <= w_page_next;
      r_ev_ack  <= w_ev_ack_next;
      r_hold    <= w_hold_next;
      // A new request in the grant cycle survives the clear.
      r_pending <= (r_pending & ~w_clear) | ev_req;
    end
  end

  assign ev_ack      = r_ev_ack;
  assign page        = r_page;
  assign an          = r_an;
  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign frame_tick  = r_frame_tick;

endmodule
